vga_timing_gen: RTL and testbench

// - Raster timing generator feeding the colorizer: owns the h/v pixel counters, generates

---
 rtl/vga_timing_gen_pkg.sv | 43 ++++
 rtl/vga_timing_gen_if.sv | 29 ++
 rtl/vga_timing_gen_sync_delay_line.sv | 40 ++++
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants and types for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel tick.
package vga_timing_gen_pkg;

    // Raster counters are 12 bits wide, so neither total may exceed 4096.
    localparam int COUNT_W   = 12;
    localparam int MAX_TOTAL = 1 << COUNT_W;

    // Default horizontal timing, in pixel ticks.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    // Default vertical timing, in lines.
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Default sync windows: [start, end) in counter units.
    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    typedef logic [COUNT_W-1:0] count_t;

    // Bundle of the three timing flags that travel through the delay line.
    typedef struct packed {
        logic video_on;
        logic horiz_sync;
        logic vert_sync;
    } sync_bus_t;

    // True when x lies in the half-open window [lo, hi).
    function automatic logic in_window(input count_t x, input int lo, input int hi);
        return (int'(x) >= lo) && (int'(x) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus between the timing generator (master) and the colorizer (slave).
// The colorizer supplies the pixel tick; the generator returns position and timing flags.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    logic   pix_en;
    count_t pixel_column;
    count_t pixel_row;
    logic   video_on;
    logic   horiz_sync;
    logic   vert_sync;
    logic   line_start;
    logic   frame_start;

    modport master (
        input  pix_en,
        output pixel_column, pixel_row,
        output video_on, horiz_sync, vert_sync,
        output line_start, frame_start
    );

    modport slave (
        output pix_en,
        input  pixel_column, pixel_row,
        input  video_on, horiz_sync, vert_sync,
        input  line_start, frame_start
    );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Enable-gated shift register that delays the timing flags so they line up
// with RGB coming out of the map/icon lookup. Depth 0 degenerates to a wire.
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        // No storage: clock, reset and enable are intentionally unused here.
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst_n, en};
        assign dout        = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_p [DEPTH];

        // Shift one position per pixel tick; reset loads the idle pattern everywhere.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_p[i] <= RESET_VAL;
                end
            end else if (en) begin
                stage_p[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_p[i] <= stage_p[i-1];
                end
            end
        end

        assign dout = stage_p[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: owns the horizontal/vertical pixel counters, decodes
// video_on and the two syncs, and delays those flags by PIPE_DLY pixel ticks so
// they stay aligned with the registered RGB from the colorizer's lookups.
// pixel_column/pixel_row are undelayed so the lookup can start immediately.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 1
) (
    input  logic clk,
    input  logic rst_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam count_t H_LAST = count_t'(H_TOTAL - 1);
    localparam count_t V_LAST = count_t'(V_TOTAL - 1);

    // Pattern held by the flag registers during reset and blanking start-up.
    localparam sync_bus_t IDLE = '{video_on: 1'b0, horiz_sync: ~SYNC_POL, vert_sync: ~SYNC_POL};

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
    end

    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_dly_check
        $error("vga_timing_gen: PIPE_DLY must be within 0..4");
    end

    count_t    h;
    count_t    v;
    count_t    h_next;
    count_t    v_next;
    sync_bus_t raw;
    sync_bus_t dec_p0;
    sync_bus_t dly_out;
    logic      line_start_q;
    logic      frame_start_q;

    // Next raster position: wrap the column at the end of a line, the row at the end of a frame.
    always_comb begin
        h_next = h + count_t'(1);
        v_next = v;
        if (h == H_LAST) begin
            h_next = '0;
            v_next = (v == V_LAST) ? '0 : v + count_t'(1);
        end
    end

    // Decode from the position the counters are about to take, so the flags register alongside it.
    assign raw = '{
        video_on:   in_window(h_next, 0, H_ACTIVE) && in_window(v_next, 0, V_ACTIVE),
        horiz_sync: in_window(h_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL,
        vert_sync:  in_window(v_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL
    };

    // Counters, decoded flags and start pulses advance only on a pixel tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h             <= '0;
            v             <= '0;
            dec_p0        <= IDLE;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (vga.pix_en) begin
                h             <= h_next;
                v             <= v_next;
                dec_p0        <= raw;
                line_start_q  <= (h_next == '0);
                frame_start_q <= (h_next == '0) && (v_next == '0);
            end
        end
    end

    // Align the flags with the colorizer's lookup latency.
    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL (IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (vga.pix_en),
        .din   (dec_p0),
        .dout  (dly_out)
    );

    assign vga.pixel_column = h;
    assign vga.pixel_row    = v;
    assign vga.video_on     = dly_out.video_on;
    assign vga.horiz_sync   = dly_out.horiz_sync;
    assign vga.vert_sync    = dly_out.vert_sync;
    assign vga.line_start   = line_start_q;
    assign vga.frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (640x480 with delay 0 and 2, and a
// small raster with delay 1) compared against a tick-count reference model.
module tb_vga_timing_gen;

    typedef struct {
        int   ha, hf, hs, hb;
        int   va, vf, vs, vb;
        int   dly;
        logic pol;
    } timing_t;

    localparam logic [28:0] RST_VEC = {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .SYNC_POL(1'b0), .PIPE_DLY(0)
    ) dut_a (.clk(clk), .rst_n(rst_a), .vga(if_a));

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .SYNC_POL(1'b0), .PIPE_DLY(2)
    ) dut_b (.clk(clk), .rst_n(rst_b), .vga(if_b));

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b0), .PIPE_DLY(1)
    ) dut_c (.clk(clk), .rst_n(rst_c), .vga(if_c));

    int      n_tests = 0;
    int      n_fail  = 0;
    longint  t_a, t_b, t_c;
    logic    tk_a, tk_b, tk_c;
    timing_t tm_a, tm_b, tm_c;

    // Expected outputs after t pixel ticks since reset; ticked = last edge was a tick.
    function automatic logic [28:0] model(input timing_t tm, input longint t, input logic ticked);
        longint ht, vt, col, row, d, dc, dr;
        logic   von, hs, vs, ls, fs;
        ht  = tm.ha + tm.hf + tm.hs + tm.hb;
        vt  = tm.va + tm.vf + tm.vs + tm.vb;
        col = t % ht;
        row = (t / ht) % vt;
        von = 1'b0;
        hs  = ~tm.pol;
        vs  = ~tm.pol;
        if (t - tm.dly >= 1) begin
            d   = t - tm.dly;
            dc  = d % ht;
            dr  = (d / ht) % vt;
            von = (dc < tm.ha) && (dr < tm.va);
            hs  = (dc >= tm.ha + tm.hf && dc < tm.ha + tm.hf + tm.hs) ? tm.pol : ~tm.pol;
            vs  = (dr >= tm.va + tm.vf && dr < tm.va + tm.vf + tm.vs) ? tm.pol : ~tm.pol;
        end
        ls = ticked && (col == 0);
        fs = ls && (row == 0);
        return {col[11:0], row[11:0], von, hs, vs, ls, fs};
    endfunction

    function automatic logic [28:0] got_a();
        return {if_a.pixel_column, if_a.pixel_row, if_a.video_on, if_a.horiz_sync,
                if_a.vert_sync, if_a.line_start, if_a.frame_start};
    endfunction

    function automatic logic [28:0] got_b();
        return {if_b.pixel_column, if_b.pixel_row, if_b.video_on, if_b.horiz_sync,
                if_b.vert_sync, if_b.line_start, if_b.frame_start};
    endfunction

    function automatic logic [28:0] got_c();
        return {if_c.pixel_column, if_c.pixel_row, if_c.video_on, if_c.horiz_sync,
                if_c.vert_sync, if_c.line_start, if_c.frame_start};
    endfunction

    task automatic drive_a(input logic r, input logic e);
        @(negedge clk);
        rst_a = r;
        if_a.pix_en = e;
        @(posedge clk);
        if (!r) begin t_a = 0; tk_a = 1'b0; end
        else if (e) begin t_a++; tk_a = 1'b1; end
        else tk_a = 1'b0;
        #1;
    endtask

    task automatic drive_b(input logic r, input logic e);
        @(negedge clk);
        rst_b = r;
        if_b.pix_en = e;
        @(posedge clk);
        if (!r) begin t_b = 0; tk_b = 1'b0; end
        else if (e) begin t_b++; tk_b = 1'b1; end
        else tk_b = 1'b0;
        #1;
    endtask

    task automatic drive_c(input logic r, input logic e);
        @(negedge clk);
        rst_c = r;
        if_c.pix_en = e;
        @(posedge clk);
        if (!r) begin t_c = 0; tk_c = 1'b0; end
        else if (e) begin t_c++; tk_c = 1'b1; end
        else tk_c = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        if_a.pix_en = 1'b1; if_b.pix_en = 1'b1; if_c.pix_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            n_tests += 3;
            if (got_a() !== RST_VEC) begin n_fail++; $display("FAIL reset_a clk=%0d got=%h expected=%h", k, got_a(), RST_VEC); end
            if (got_b() !== RST_VEC) begin n_fail++; $display("FAIL reset_b clk=%0d got=%h expected=%h", k, got_b(), RST_VEC); end
            if (got_c() !== RST_VEC) begin n_fail++; $display("FAIL reset_c clk=%0d got=%h expected=%h", k, got_c(), RST_VEC); end
        end
        t_a = 0; t_b = 0; t_c = 0;
        tk_a = 1'b0; tk_b = 1'b0; tk_c = 1'b0;
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        if_a.pix_en = 1'b0; if_b.pix_en = 1'b0; if_c.pix_en = 1'b0;
    endtask

    task automatic test_line_timing();
        logic [28:0] exp, got;
        int hs_low, last_ls, period;
        hs_low = 0; last_ls = -1; period = -1;
        drive_a(1'b0, 1'b1);
        for (int k = 0; k < 2500; k++) begin
            drive_a(1'b1, 1'b1);
            exp = model(tm_a, t_a, tk_a);
            got = got_a();
            n_tests += 3;
            if (got !== exp) begin n_fail++; $display("FAIL line_model k=%0d got=%h expected=%h", k, got, exp); end
            if (if_a.horiz_sync !== !(if_a.pixel_column >= 12'd656 && if_a.pixel_column <= 12'd751)) begin
                n_fail++; $display("FAIL hsync_window col=%0d got=%b", if_a.pixel_column, if_a.horiz_sync);
            end
            if (if_a.video_on !== (if_a.pixel_column < 12'd640)) begin
                n_fail++; $display("FAIL video_window col=%0d got=%b", if_a.pixel_column, if_a.video_on);
            end
            if (if_a.pixel_row == 12'd1 && if_a.horiz_sync == 1'b0) hs_low++;
            if (if_a.line_start) begin
                if (last_ls >= 0) period = k - last_ls;
                last_ls = k;
            end
        end
        n_tests += 2;
        if (hs_low !== 96) begin n_fail++; $display("FAIL hsync_width got=%0d expected=96", hs_low); end
        if (period !== 800) begin n_fail++; $display("FAIL line_period got=%0d expected=800", period); end
    endtask

    task automatic test_pipe_delay();
        logic [28:0] exp, got;
        logic prev_hs, prev_von;
        int hs_fall_col, von_rise_col;
        prev_hs = 1'b1; prev_von = 1'b0; hs_fall_col = -1; von_rise_col = -1;
        drive_b(1'b0, 1'b1);
        for (int k = 0; k < 1700; k++) begin
            drive_b(1'b1, 1'b1);
            exp = model(tm_b, t_b, tk_b);
            got = got_b();
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL delay_model k=%0d got=%h expected=%h", k, got, exp); end
            if (prev_hs && !if_b.horiz_sync && hs_fall_col < 0) hs_fall_col = int'(if_b.pixel_column);
            if (!prev_von && if_b.video_on && if_b.pixel_row == 12'd1 && von_rise_col < 0)
                von_rise_col = int'(if_b.pixel_column);
            prev_hs  = if_b.horiz_sync;
            prev_von = if_b.video_on;
        end
        n_tests += 2;
        if (hs_fall_col !== 658) begin n_fail++; $display("FAIL hsync_fall_col got=%0d expected=658", hs_fall_col); end
        if (von_rise_col !== 2) begin n_fail++; $display("FAIL video_rise_col got=%0d expected=2", von_rise_col); end
    endtask

    task automatic test_slow_tick();
        logic [28:0] exp, got, prev;
        logic e, prev_hs;
        int last_fall, period, ls_cnt;
        last_fall = -1; period = -1; ls_cnt = 0; prev_hs = 1'b1;
        drive_b(1'b0, 1'b0);
        prev = got_b();
        for (int k = 0; k < 8000; k++) begin
            e = (k % 4 == 0);
            drive_b(1'b1, e);
            exp = model(tm_b, t_b, tk_b);
            got = got_b();
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL slow_model k=%0d got=%h expected=%h", k, got, exp); end
            if (!e) begin
                n_tests++;
                if (got[28:2] !== prev[28:2] || got[1:0] !== 2'b00) begin
                    n_fail++; $display("FAIL slow_frozen k=%0d got=%h previous=%h", k, got, prev);
                end
            end
            if (prev_hs && !if_b.horiz_sync) begin
                if (last_fall >= 0) period = k - last_fall;
                last_fall = k;
            end
            if (if_b.line_start) ls_cnt++;
            prev_hs = if_b.horiz_sync;
            prev = got;
        end
        n_tests += 2;
        if (period !== 3200) begin n_fail++; $display("FAIL slow_hsync_period got=%0d expected=3200", period); end
        if (ls_cnt !== 2) begin n_fail++; $display("FAIL slow_line_pulses got=%0d expected=2", ls_cnt); end
    endtask

    task automatic test_midframe_reset();
        logic [28:0] exp, got;
        drive_b(1'b0, 1'b1);
        for (int k = 0; k < 1900; k++) begin
            drive_b(1'b1, 1'b1);
            exp = model(tm_b, t_b, tk_b);
            got = got_b();
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL pre_reset_model k=%0d got=%h expected=%h", k, got, exp); end
        end
        n_tests++;
        if ({if_b.pixel_column, if_b.pixel_row} !== {12'd300, 12'd2}) begin
            n_fail++; $display("FAIL reset_position got=%0d,%0d expected=300,2", if_b.pixel_column, if_b.pixel_row);
        end
        drive_b(1'b0, 1'b1);
        n_tests++;
        if (got_b() !== RST_VEC) begin n_fail++; $display("FAIL midframe_reset got=%h expected=%h", got_b(), RST_VEC); end
        for (int k = 0; k < 900; k++) begin
            drive_b(1'b1, 1'b1);
            exp = model(tm_b, t_b, tk_b);
            got = got_b();
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL post_reset_model k=%0d got=%h expected=%h", k, got, exp); end
        end
    endtask

    task automatic test_full_frame();
        logic [28:0] exp, got;
        int ls_cnt, fs_cnt, vs_cnt, wraps;
        logic [11:0] prev_row;
        ls_cnt = 0; fs_cnt = 0; vs_cnt = 0; wraps = 0; prev_row = 12'd0;
        drive_c(1'b0, 1'b1);
        for (int k = 0; k < 1088; k++) begin
            drive_c(1'b1, 1'b1);
            exp = model(tm_c, t_c, tk_c);
            got = got_c();
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL frame_model k=%0d got=%h expected=%h", k, got, exp); end
            if (if_c.line_start) ls_cnt++;
            if (if_c.frame_start) fs_cnt++;
            if (!if_c.vert_sync) vs_cnt++;
            if (prev_row == 12'd16 && if_c.pixel_row == 12'd0) wraps++;
            prev_row = if_c.pixel_row;
        end
        n_tests += 4;
        if (fs_cnt !== 2) begin n_fail++; $display("FAIL frame_pulses got=%0d expected=2", fs_cnt); end
        if (ls_cnt !== 34) begin n_fail++; $display("FAIL frame_line_pulses got=%0d expected=34", ls_cnt); end
        if (vs_cnt !== 128) begin n_fail++; $display("FAIL vsync_low_clks got=%0d expected=128", vs_cnt); end
        if (wraps !== 2) begin n_fail++; $display("FAIL row_wraps got=%0d expected=2", wraps); end
    endtask

    task automatic test_random_ticks();
        logic [28:0] exp, got;
        logic r, e;
        drive_c(1'b0, 1'b1);
        for (int k = 0; k < 3000; k++) begin
            e = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 599) != 0);
            drive_c(r, e);
            exp = model(tm_c, t_c, tk_c);
            got = got_c();
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL random_model k=%0d got=%h expected=%h", k, got, exp); end
        end
    endtask

    initial begin
        tm_a = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, dly: 0, pol: 1'b0};
        tm_b = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, dly: 2, pol: 1'b0};
        tm_c = '{ha: 20, hf: 3, hs: 5, hb: 4, va: 10, vf: 2, vs: 2, vb: 3, dly: 1, pol: 1'b0};
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        if_a.pix_en = 1'b0; if_b.pix_en = 1'b0; if_c.pix_en = 1'b0;
        t_a = 0; t_b = 0; t_c = 0;
        tk_a = 1'b0; tk_b = 1'b0; tk_c = 1'b0;

        test_reset();
        test_line_timing();
        test_pipe_delay();
        test_slow_tick();
        test_midframe_reset();
        test_full_frame();
        test_random_ticks();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
